// File: rtl/video_frame_writer.sv
// video_frame_writer: write-side framer for the DDR3 two-port frame buffer.
// Optional macro VFW_GEOM_STATS_EN builds the meas_h/meas_v latches.

module video_frame_writer #(
  parameter int         H_ACTIVE = 1920,
  parameter int         V_ACTIVE = 1080,
  parameter bit         VS_POL   = 1'b1,
  parameter logic [7:0] ALPHA    = 8'hFF,
  parameter int         SKIP_W   = 4
) (
  input  logic              hdmi_clk148m5,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [SKIP_W-1:0] frame_skip,
  input  logic              vid_vsync,
  input  logic              vid_den,
  input  logic [23:0]       vid_pixel,
  input  logic              wrfifo_full,
  input  logic              err_clr,
  output logic              wr_load,
  output logic              wrfifo_wren,
  output logic [31:0]       wrfifo_din,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_geom,
  output logic              err_ovf,
  output logic [12:0]       meas_h,
  output logic [11:0]       meas_v
);

  typedef enum logic [1:0] {
    IDLE, WAIT_VS, WRITE, SKIP
  } state_t;

  localparam logic [12:0] H_LIM = 13'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [12:0]       x;
  logic [11:0]       y;
  logic              vs_s1, vs_d;
  logic              den_s1, den_d;
  logic [23:0]       pix_s1;

  // stage 1: register the incoming stream, normalise vsync polarity
  always_ff @(posedge hdmi_clk148m5 or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1  <= 1'b0;
      vs_d   <= 1'b0;
      den_s1 <= 1'b0;
      den_d  <= 1'b0;
      pix_s1 <= '0;
    end else begin
      vs_s1  <= (vid_vsync == VS_POL);
      vs_d   <= vs_s1;
      den_s1 <= vid_den;
      den_d  <= den_s1;
      pix_s1 <= vid_pixel;
    end
  end

  logic        vs_rise, den_fall, in_wr, line_open;
  logic        accept, geom_set, ovf_set;
  logic        write_next;
  logic [12:0] x_inc;
  logic [11:0] y_inc, y_close;

  assign vs_rise   = vs_s1 & ~vs_d;
  assign den_fall  = ~den_s1 & den_d;
  assign in_wr     = (state == WRITE);
  assign x_inc     = (x == 13'h1FFF) ? x : x + 13'd1;
  assign y_inc     = (y == 12'hFFF) ? y : y + 12'd1;
  assign line_open = den_s1 | den_fall;
  assign y_close   = line_open ? y_inc : y;

  assign accept  = in_wr & ~vs_rise & den_s1
                 & (x < H_LIM) & (y < V_LIM);
  assign ovf_set = accept & wrfifo_full;

  // geometry faults: stray pixels, bad line length, bad line count
  always_comb begin
    geom_set = 1'b0;
    if (in_wr) begin
      if (vs_rise)
        geom_set = (y_close != V_LIM) | den_s1
                 | (den_fall & (x != H_LIM));
      else if (den_s1)
        geom_set = ~accept;
      else if (den_fall)
        geom_set = (x != H_LIM);
    end
  end

  // will the frame following the current vsync be written
  always_comb begin
    write_next = in_wr;
    if (vs_rise) begin
      unique case (state)
        IDLE:    write_next = 1'b0;
        WAIT_VS: write_next = 1'b1;
        WRITE:   write_next = enable & (frame_skip == '0);
        SKIP:    write_next = enable
                            & (skip_cnt <= SKIP_W'(1));
      endcase
    end
  end

  // stage 2 outputs, frame FSM and position counters
  always_ff @(posedge hdmi_clk148m5 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      wr_load     <= 1'b0;
      wrfifo_wren <= 1'b0;
      wrfifo_din  <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      err_geom    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      wr_load     <= vs_s1 & write_next;
      wrfifo_wren <= accept & ~wrfifo_full;
      if (accept)
        wrfifo_din <= {pix_s1, ALPHA};
      err_geom <= geom_set | (err_geom & ~err_clr);
      err_ovf  <= ovf_set | (err_ovf & ~err_clr);

      unique case (1'b1)
        vs_rise: begin
          x <= '0;
          y <= '0;
        end
        den_fall: begin
          x <= '0;
          y <= y_inc;
        end
        den_s1:  x <= x_inc;
        default: ;
      endcase

      unique case (state)
        IDLE:
          if (enable)
            state <= WAIT_VS;
        WAIT_VS:
          if (vs_rise) begin
            state    <= WRITE;
            skip_cnt <= frame_skip;
          end
        WRITE:
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            if (!enable)
              state <= IDLE;
            else if (frame_skip != '0) begin
              state    <= SKIP;
              skip_cnt <= frame_skip;
            end
          end
        SKIP:
          if (vs_rise) begin
            skip_cnt <= skip_cnt - SKIP_W'(1);
            if (skip_cnt <= SKIP_W'(1))
              state <= enable ? WRITE : IDLE;
          end
      endcase
    end
  end

`ifdef VFW_GEOM_STATS_EN
  logic [12:0] meas_h_q;
  logic [11:0] meas_v_q;

  // latch measured line length and line count
  always_ff @(posedge hdmi_clk148m5 or negedge reset_n) begin
    if (!reset_n) begin
      meas_h_q <= '0;
      meas_v_q <= '0;
    end else begin
      if (den_fall)
        meas_h_q <= x;
      if (vs_rise)
        meas_v_q <= y_close;
    end
  end

  assign meas_h = meas_h_q;
  assign meas_v = meas_v_q;
`else
  assign meas_h = '0;
  assign meas_v = '0;
`endif

endmodule
